// File: rtl/ce_pkg.sv
// Shared CE definitions: FFT size limits, address width, sequencer states and
// the FFT-size legality check used across the CE blocks.
package ce_pkg;
   localparam int FFTPTS_MAX = 2048;
   localparam int FFTPTS_MIN = 8;
   localparam int AW         = $clog2(FFTPTS_MAX);
   localparam int NW         = 12;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WAIT,
      ST_RUN,
      ST_FLUSH,
      ST_SKIP
   } seq_state_t;

   function automatic logic fftpts_legal(input logic [NW-1:0] n);
      return (n >= NW'(FFTPTS_MIN)) && (n <= NW'(FFTPTS_MAX)) &&
             ((n & (n - 1'b1)) == '0);
   endfunction
endpackage

// File: rtl/ce_window_seq_if.sv
// Frame read bus: RAM read strobe/addresses plus the aligned output stream flags.
interface ce_window_seq_if;
   import ce_pkg::*;

   logic          rd_en;
   logic [AW-1:0] rd_addr_fwd;
   logic [AW-1:0] rd_addr_rev;
   logic          out_ready;
   logic          out_valid;
   logic          out_sop;
   logic          out_eop;
   logic          out_rev_zero;
   logic [NW-1:0] fftpts_out;

   modport master (
      output rd_en, rd_addr_fwd, rd_addr_rev,
      output out_valid, out_sop, out_eop, out_rev_zero, fftpts_out,
      input  out_ready
   );

   modport slave (
      input  rd_en, rd_addr_fwd, rd_addr_rev,
      input  out_valid, out_sop, out_eop, out_rev_zero, fftpts_out,
      output out_ready
   );
endinterface

// File: rtl/ce_window_seq_addr.sv
// Beat counter with forward address cnt and reversed address (N - cnt) mod N,
// plus first/last beat flags.
module ce_window_seq_addr
   import ce_pkg::*;
(
   input  logic          clk,
   input  logic          rst_sync,
   input  logic          clr,
   input  logic          adv,
   input  logic [NW-1:0] n,
   output logic [AW-1:0] addr_fwd,
   output logic [AW-1:0] addr_rev,
   output logic          first,
   output logic          last
);
   logic [AW-1:0] cnt;
   logic [AW-1:0] n_lo;

   always_ff @(posedge clk) begin
      if (rst_sync || clr) cnt <= '0;
      else if (adv)        cnt <= cnt + 1'b1;
   end

   // N=2048 truncates to 0 here; the modulo-2^AW arithmetic still yields 2048-cnt.
   assign n_lo     = n[AW-1:0];
   assign addr_fwd = cnt;
   assign addr_rev = (n_lo - cnt) & (n_lo - 1'b1);
   assign first    = (cnt == '0);
   assign last     = (NW'(cnt) == (n - 1'b1));
endmodule

// File: rtl/ce_window_seq.sv
// CE window frame read sequencer: waits for a full frame, streams paired
// forward/reverse reads under backpressure, then releases the buffer.
module ce_window_seq
   import ce_pkg::*;
(
   input  logic               clk,
   input  logic               rst_sync,
   input  logic               enable,
   input  logic [NW-1:0]      fftpts_cfg,
   input  logic               frm_avail,
   output logic               frm_release,
   output logic               cfg_err,
   output logic [15:0]        frm_cnt,
   ce_window_seq_if.master    bus
);
   seq_state_t    state, nxt;
   logic          rd_en, start, rel;
   logic          first, last;
   logic [AW-1:0] addr_fwd, addr_rev;
   logic [NW-1:0] n_q;
   logic          vld_q, sop_q, eop_q, rz_q;

   ce_window_seq_addr u_addr (
      .clk      (clk),
      .rst_sync (rst_sync),
      .clr      (start),
      .adv      (rd_en),
      .n        (n_q),
      .addr_fwd (addr_fwd),
      .addr_rev (addr_rev),
      .first    (first),
      .last     (last)
   );

   always_ff @(posedge clk) begin
      if (rst_sync) state <= ST_IDLE;
      else          state <= nxt;
   end

   // Disable wins over a pending frame in WAIT; RUN/FLUSH never look at enable.
   always_comb begin
      nxt   = state;
      rd_en = 1'b0;
      start = 1'b0;
      rel   = 1'b0;
      case (state)
         ST_IDLE:  if (enable) nxt = ST_WAIT;
         ST_WAIT: begin
            if (!enable) nxt = ST_IDLE;
            else if (frm_avail) begin
               start = 1'b1;
               nxt   = fftpts_legal(fftpts_cfg) ? ST_RUN : ST_SKIP;
            end
         end
         ST_RUN: begin
            rd_en = bus.out_ready;
            if (rd_en && last) nxt = ST_FLUSH;
         end
         ST_FLUSH: begin
            rel = 1'b1;
            nxt = ST_WAIT;
         end
         ST_SKIP: begin
            rel = 1'b1;
            nxt = ST_WAIT;
         end
         default: nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst_sync) begin
         n_q     <= '0;
         vld_q   <= 1'b0;
         sop_q   <= 1'b0;
         eop_q   <= 1'b0;
         rz_q    <= 1'b0;
         cfg_err <= 1'b0;
         frm_cnt <= '0;
      end else begin
         if (start) n_q <= fftpts_cfg;
         // Flags ride one cycle behind the read to line up with RAM data.
         vld_q <= rd_en;
         sop_q <= rd_en & first;
         eop_q <= rd_en & last;
         rz_q  <= rd_en & first;
         if (state == ST_SKIP)  cfg_err <= 1'b1;
         if (state == ST_FLUSH) frm_cnt <= frm_cnt + 16'd1;
      end
   end

   assign frm_release      = rel;
   assign bus.rd_en        = rd_en;
   assign bus.rd_addr_fwd  = addr_fwd;
   assign bus.rd_addr_rev  = addr_rev;
   assign bus.out_valid    = vld_q;
   assign bus.out_sop      = sop_q;
   assign bus.out_eop      = eop_q;
   assign bus.out_rev_zero = rz_q;
   assign bus.fftpts_out   = n_q;
endmodule

// File: tb/tb_ce_window_seq.sv
// Directed bench for ce_window_seq: reads, flags and releases are logged on the
// falling edge and compared against hand-derived sequences.
module tb_ce_window_seq;
   logic        clk;
   logic        rst_sync;
   logic        enable;
   logic [11:0] fftpts_cfg;
   logic        frm_avail;
   logic        frm_release;
   logic        cfg_err;
   logic [15:0] frm_cnt;
   logic        rdy_drv;
   logic        toggle;
   int          cyc;

   ce_window_seq_if bus ();

   ce_window_seq dut (
      .clk         (clk),
      .rst_sync    (rst_sync),
      .enable      (enable),
      .fftpts_cfg  (fftpts_cfg),
      .frm_avail   (frm_avail),
      .frm_release (frm_release),
      .cfg_err     (cfg_err),
      .frm_cnt     (frm_cnt),
      .bus         (bus)
   );

   // Pattern mode drops ready one cycle in every three.
   assign bus.out_ready = toggle ? ((cyc % 3) != 2) : rdy_drv;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int   cyc;
      logic sop;
      logic eop;
      logic rz;
      int   n;
   } beat_t;

   int    fwd_q[$];
   int    rev_q[$];
   int    rdcyc_q[$];
   beat_t bq[$];
   int    rel_cnt = 0;
   int    rel_cyc = 0;
   int    viol    = 0;
   logic  prev_rdy = 1'b1;

   always @(negedge clk) begin
      beat_t b;
      if (bus.rd_en) begin
         fwd_q.push_back(int'(bus.rd_addr_fwd));
         rev_q.push_back(int'(bus.rd_addr_rev));
         rdcyc_q.push_back(cyc);
         if (!bus.out_ready) viol++;
      end
      if (bus.out_valid) begin
         b.cyc = cyc;
         b.sop = bus.out_sop;
         b.eop = bus.out_eop;
         b.rz  = bus.out_rev_zero;
         b.n   = int'(bus.fftpts_out);
         bq.push_back(b);
         if (!prev_rdy) viol++;
      end
      if (frm_release) begin
         rel_cnt++;
         rel_cyc = cyc;
      end
      prev_rdy = bus.out_ready;
   end

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string tag, input int obs, input int exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d want %0d", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_rel(input int nrel, input int budget, input string tag);
      int seen = 0;
      int k = 0;
      while (seen < nrel && k < budget) begin
         @(negedge clk);
         k++;
         if (frm_release) seen++;
      end
      #1;
      chk({tag, "_release"}, seen, nrel);
   endtask

   task automatic wait_fwd(input int a, input int budget, input string tag);
      int found = 0;
      int k = 0;
      while (found == 0 && k < budget) begin
         @(negedge clk);
         k++;
         if (bus.rd_en && int'(bus.rd_addr_fwd) == a) found = 1;
      end
      chk(tag, found, 1);
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_rd_en"}, int'(bus.rd_en), 0);
      chk({tag, "_valid"}, int'(bus.out_valid), 0);
      chk({tag, "_flags"}, int'({bus.out_sop, bus.out_eop, bus.out_rev_zero}), 0);
      chk({tag, "_fwd"}, int'(bus.rd_addr_fwd), 0);
      chk({tag, "_rev"}, int'(bus.rd_addr_rev), 0);
      chk({tag, "_fftpts"}, int'(bus.fftpts_out), 0);
      chk({tag, "_cfg_err"}, int'(cfg_err), 0);
      chk({tag, "_frm_cnt"}, int'(frm_cnt), 0);
      chk({tag, "_release"}, int'(frm_release), 0);
   endtask

   int f0, b0, r0, v0, c, bad, ns, ne;
   int ill[3] = '{100, 24, 4096};

   initial begin
      rst_sync = 1'b1; enable = 1'b0; fftpts_cfg = '0; frm_avail = 1'b0;
      rdy_drv = 1'b1; toggle = 1'b0;
      tick(3);
      chk_reset("rst");
      rst_sync = 1'b0;
      enable   = 1'b1;
      tick(3);

      // N=16, unstalled
      f0 = fwd_q.size(); b0 = bq.size();
      fftpts_cfg = 12'd16; frm_avail = 1'b1; c = cyc;
      wait_rel(1, 100, "t1");
      tick(1); frm_avail = 1'b0;
      chk("t1_nrd", fwd_q.size() - f0, 16);
      chk("t1_nbeat", bq.size() - b0, 16);
      chk("t1_first_rd_cyc", rdcyc_q[f0], c + 1);
      bad = 0;
      for (int i = 0; i < 16; i++) begin
         if (fwd_q[f0+i] != i) bad++;
         if (rev_q[f0+i] != ((i == 0) ? 0 : 16 - i)) bad++;
      end
      chk("t1_addr_seq", bad, 0);
      chk("t1_sop0", int'({bq[b0].sop, bq[b0].rz}), 3);
      chk("t1_eop15", int'(bq[b0+15].eop), 1);
      ns = 0; ne = 0;
      for (int i = 0; i < 16; i++) begin
         ns += int'(bq[b0+i].sop);
         ne += int'(bq[b0+i].eop);
      end
      chk("t1_nsop_neop", ns * 100 + ne, 101);
      chk("t1_beat_span", bq[b0+15].cyc - bq[b0].cyc, 15);
      chk("t1_rel_cyc", rel_cyc, rdcyc_q[f0+15] + 1);
      chk("t1_frm_cnt", int'(frm_cnt), 1);
      chk("t1_fftpts", int'(bus.fftpts_out), 16);
      tick(2);

      // N=2048 with ready dropping every third cycle
      f0 = fwd_q.size(); b0 = bq.size(); v0 = viol;
      fftpts_cfg = 12'd2048; toggle = 1'b1; frm_avail = 1'b1;
      wait_rel(1, 5000, "t2");
      tick(1); frm_avail = 1'b0; toggle = 1'b0;
      chk("t2_nrd", fwd_q.size() - f0, 2048);
      chk("t2_nbeat", bq.size() - b0, 2048);
      bad = 0;
      for (int i = 0; i < 2048; i++) begin
         if (fwd_q[f0+i] != i) bad++;
         if (rev_q[f0+i] != ((2048 - i) & 2047)) bad++;
      end
      chk("t2_addr_seq", bad, 0);
      chk("t2_ready_viol", viol - v0, 0);
      chk("t2_sop_eop", int'({bq[b0].sop, bq[b0+2047].eop}), 3);
      chk("t2_frm_cnt", int'(frm_cnt), 2);
      tick(2);

      // illegal sizes go to SKIP
      f0 = fwd_q.size(); b0 = bq.size(); r0 = rel_cnt;
      chk("t3_cfg_err_pre", int'(cfg_err), 0);
      for (int k = 0; k < 3; k++) begin
         fftpts_cfg = 12'(ill[k]); frm_avail = 1'b1;
         wait_rel(1, 20, "t3");
         tick(1); frm_avail = 1'b0;
         if (k == 0) chk("t3_fftpts_100", int'(bus.fftpts_out), 100);
         tick(2);
      end
      chk("t3_nrd", fwd_q.size() - f0, 0);
      chk("t3_nbeat", bq.size() - b0, 0);
      chk("t3_nrel", rel_cnt - r0, 3);
      chk("t3_cfg_err", int'(cfg_err), 1);
      chk("t3_frm_cnt", int'(frm_cnt), 2);

      // two frames back to back, size changed mid-frame
      f0 = fwd_q.size(); b0 = bq.size();
      fftpts_cfg = 12'd64; frm_avail = 1'b1;
      wait_fwd(20, 100, "t4_reach20");
      fftpts_cfg = 12'd8;
      wait_rel(2, 300, "t4");
      tick(1); frm_avail = 1'b0;
      chk("t4_nrd", fwd_q.size() - f0, 72);
      chk("t4_nbeat", bq.size() - b0, 72);
      bad = 0;
      for (int i = 0; i < 64; i++) if (bq[b0+i].n != 64) bad++;
      for (int i = 64; i < 72; i++) if (bq[b0+i].n != 8) bad++;
      chk("t4_fftpts_beats", bad, 0);
      bad = 0;
      for (int i = 0; i < 8; i++) if (fwd_q[f0+64+i] != i) bad++;
      chk("t4_f2_fwd", bad, 0);
      chk("t4_eop_sop", int'({bq[b0+63].eop, bq[b0+64].sop, bq[b0+71].eop}), 7);
      chk("t4_gap", bq[b0+64].cyc - bq[b0+63].cyc, 3);
      chk("t4_frm_cnt", int'(frm_cnt), 4);
      tick(2);

      // reset in the middle of a frame
      fftpts_cfg = 12'd64; frm_avail = 1'b1;
      wait_fwd(30, 100, "t5_reach30");
      rst_sync = 1'b1;
      @(posedge clk); #1;
      chk_reset("t5_rst");
      fftpts_cfg = 12'd16;
      f0 = fwd_q.size(); b0 = bq.size();
      rst_sync = 1'b0;
      wait_rel(1, 100, "t5");
      tick(1); frm_avail = 1'b0;
      chk("t5_nrd", fwd_q.size() - f0, 16);
      chk("t5_first_fwd", fwd_q[f0], 0);
      chk("t5_sop", int'(bq[b0].sop), 1);
      chk("t5_frm_cnt", int'(frm_cnt), 1);
      tick(2);

      // enable dropped mid-frame
      f0 = fwd_q.size(); r0 = rel_cnt;
      fftpts_cfg = 12'd8; frm_avail = 1'b1;
      wait_fwd(3, 50, "t6_reach3");
      enable = 1'b0;
      wait_rel(1, 50, "t6");
      tick(20);
      chk("t6_nrd", fwd_q.size() - f0, 8);
      chk("t6_nrel", rel_cnt - r0, 1);
      chk("t6_frm_cnt", int'(frm_cnt), 2);
      chk("t6_idle_rd_en", int'(bus.rd_en), 0);
      frm_avail = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
